// File: rtl/matmul_stream_engine_if.sv
// Stream bundle for the matmul engine: operand input and result output.
// Engine side uses the slave modport, the feeding/draining side uses master.
interface matmul_stream_engine_if #(
  parameter int DW  = 8,
  parameter int ACW = 18
);
  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic           in_ready;
  logic           out_valid;
  logic [ACW-1:0] out_data;
  logic           out_last;
  logic           out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_stream_engine.sv
// Streamed M x K by K x N matrix multiplier with LANES row-parallel MACs.
// Loads A then B, computes C one row group/column at a time, drains C row-major.
module matmul_stream_engine #(
  parameter int DW    = 8,
  parameter int M     = 3,
  parameter int K     = 3,
  parameter int N     = 3,
  parameter int LANES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic signed_mode,
  matmul_stream_engine_if.slave s,
  output logic busy,
  output logic done
);
  localparam int ACW = 2*DW + $clog2(K);
  localparam int G   = M / LANES;
  localparam int MK  = M * K;
  localparam int KN  = K * N;
  localparam int MN  = M * N;

  function automatic int clw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int LDW = clw((MK > KN) ? MK : KN);
  localparam int AIW = clw(MK);
  localparam int BIW = clw(KN);
  localparam int CIW = clw(MN);
  localparam int KW  = clw(K);
  localparam int JW  = clw(N);
  localparam int GW  = clw(G);

  localparam logic [LDW-1:0] LD_A_LAST = LDW'(MK - 1);
  localparam logic [LDW-1:0] LD_B_LAST = LDW'(KN - 1);
  localparam logic [KW-1:0]  K_LAST    = KW'(K - 1);
  localparam logic [JW-1:0]  J_LAST    = JW'(N - 1);
  localparam logic [GW-1:0]  G_LAST    = GW'(G - 1);
  localparam logic [CIW-1:0] O_LAST    = CIW'(MN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_STORE   = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  if (M % LANES != 0) begin : g_bad_lanes
    $error("M must be a multiple of LANES");
  end
  if (K < 2) begin : g_bad_k
    $error("K must be at least 2");
  end

  logic [2:0]     state_q, state_d;
  logic           smode_q, smode_d;
  logic [LDW-1:0] ld_q, ld_d;
  logic [KW-1:0]  k_q, k_d;
  logic [JW-1:0]  j_q, j_d;
  logic [GW-1:0]  g_q, g_d;
  logic [CIW-1:0] o_q, o_d;
  logic [ACW-1:0] acc_q [LANES];
  logic [ACW-1:0] acc_d [LANES];

  logic [DW-1:0]  a_q [MK];
  logic [DW-1:0]  b_q [KN];
  logic [ACW-1:0] c_q [MN];

  logic           a_we, b_we, c_we;
  logic           in_fire, out_fire;
  logic [ACW-1:0] prod [LANES];
  logic [CIW-1:0] ci   [LANES];

  function automatic logic [ACW-1:0] ext(
    input logic [DW-1:0] v,
    input logic          sm
  );
    return sm ? {{(ACW-DW){v[DW-1]}}, v}
              : {{(ACW-DW){1'b0}}, v};
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [AIW-1:0] ai;
    logic [BIW-1:0] bi;
    logic [ACW-1:0] ea, eb;
    assign ai = AIW'((int'(g_q)*LANES + l)*K + int'(k_q));
    assign bi = BIW'(int'(k_q)*N + int'(j_q));
    assign ea = ext(a_q[ai], smode_q);
    assign eb = ext(b_q[bi], smode_q);
    // Truncation to ACW is exact: ACW covers the full K-term dot product.
    assign prod[l] = ea * eb;
    assign ci[l] = CIW'((int'(g_q)*LANES + l)*N + int'(j_q));
  end

  assign s.in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign s.out_valid = (state_q == S_DRAIN);
  assign s.out_data  = (state_q == S_DRAIN) ? c_q[o_q] : '0;
  assign s.out_last  = (state_q == S_DRAIN) && (o_q == O_LAST);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  assign in_fire  = s.in_valid && s.in_ready;
  assign out_fire = s.out_valid && s.out_ready;

  always_comb begin
    state_d = state_q;
    smode_d = smode_q;
    ld_d    = ld_q;
    k_d     = k_q;
    j_d     = j_q;
    g_d     = g_q;
    o_d     = o_q;
    a_we    = 1'b0;
    b_we    = 1'b0;
    c_we    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      acc_d[l] = acc_q[l];
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          smode_d = signed_mode;
          ld_d    = '0;
        end
      end
      S_LOAD_A: begin
        if (in_fire) begin
          a_we = 1'b1;
          if (ld_q == LD_A_LAST) begin
            state_d = S_LOAD_B;
            ld_d    = '0;
          end else begin
            ld_d = ld_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (in_fire) begin
          b_we = 1'b1;
          if (ld_q == LD_B_LAST) begin
            state_d = S_COMPUTE;
            ld_d    = '0;
            k_d     = '0;
            j_d     = '0;
            g_d     = '0;
          end else begin
            ld_d = ld_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        // k == 0 restarts the sum, which clears acc for each new (g,j).
        for (int l = 0; l < LANES; l++) begin
          acc_d[l] = ((k_q == '0) ? '0 : acc_q[l]) + prod[l];
        end
        if (k_q == K_LAST) begin
          state_d = S_STORE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_STORE: begin
        c_we    = 1'b1;
        state_d = S_COMPUTE;
        if (j_q == J_LAST) begin
          j_d = '0;
          if (g_q == G_LAST) begin
            g_d     = '0;
            o_d     = '0;
            state_d = S_DRAIN;
          end else begin
            g_d = g_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (o_q == O_LAST) begin
            state_d = S_DONE;
            o_d     = '0;
          end else begin
            o_d = o_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      smode_q <= 1'b0;
      ld_q    <= '0;
      k_q     <= '0;
      j_q     <= '0;
      g_q     <= '0;
      o_q     <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      state_q <= state_d;
      smode_q <= smode_d;
      ld_q    <= ld_d;
      k_q     <= k_d;
      j_q     <= j_d;
      g_q     <= g_d;
      o_q     <= o_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MK; i++) a_q[i] <= '0;
      for (int i = 0; i < KN; i++) b_q[i] <= '0;
      for (int i = 0; i < MN; i++) c_q[i] <= '0;
    end else begin
      if (a_we) a_q[ld_q[AIW-1:0]] <= s.in_data;
      if (b_we) b_q[ld_q[BIW-1:0]] <= s.in_data;
      if (c_we) begin
        for (int l = 0; l < LANES; l++) c_q[ci[l]] <= acc_q[l];
      end
    end
  end
endmodule

// File: tb/tb_matmul_stream_engine.sv
// Bench for matmul_stream_engine: table of jobs with constant expected C,
// scoreboard queue for results, plus stall, mid-job reset and LANES=1 runs.
module tb_matmul_stream_engine;
  localparam int ACW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start3 = 1'b0;
  logic start1 = 1'b0;
  logic signed_mode = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;
  logic busy3, busy1, done3, done1;

  always #5 clk = ~clk;

  matmul_stream_engine_if #(.DW(8), .ACW(ACW)) i3 ();
  matmul_stream_engine_if #(.DW(8), .ACW(ACW)) i1 ();

  assign i3.in_valid  = in_valid;
  assign i3.in_data   = in_data;
  assign i3.out_ready = out_ready;
  assign i1.in_valid  = in_valid;
  assign i1.in_data   = in_data;
  assign i1.out_ready = out_ready;

  matmul_stream_engine #(.DW(8), .M(3), .K(3), .N(3), .LANES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .signed_mode(signed_mode), .s(i3),
    .busy(busy3), .done(done3)
  );

  matmul_stream_engine #(.DW(8), .M(3), .K(3), .N(3), .LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .signed_mode(signed_mode), .s(i1),
    .busy(busy1), .done(done1)
  );

  logic           c_in_ready, c_out_valid, c_out_last, c_busy, c_done;
  logic [ACW-1:0] c_out_data;
  assign c_in_ready  = sel ? i1.in_ready  : i3.in_ready;
  assign c_out_valid = sel ? i1.out_valid : i3.out_valid;
  assign c_out_last  = sel ? i1.out_last  : i3.out_last;
  assign c_out_data  = sel ? i1.out_data  : i3.out_data;
  assign c_busy      = sel ? busy1 : busy3;
  assign c_done      = sel ? done1 : done3;

  typedef struct {
    bit sm;
    int a [9];
    int b [9];
    int e [9];
  } vec_t;

  vec_t vt [5];
  logic [ACW-1:0] exp_q [$];
  bit             last_q [$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic do_job(input int vi, input bit dsel, input bit gaps, input bit rst_mid);
    int n, guard, lat;
    logic [ACW-1:0] hold;
    logic [ACW-1:0] e;
    bit lst;
    bit stalled;
    sel = dsel;
    if (!rst_mid) begin
      for (int i = 0; i < 9; i++) begin
        exp_q.push_back(ACW'(vt[vi].e[i]));
        last_q.push_back(i == 8);
      end
    end
    @(negedge clk);
    signed_mode = vt[vi].sm;
    if (dsel) start1 = 1'b1;
    else start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    start1 = 1'b0;
    n = 0;
    guard = 0;
    while (n < 18 && guard < 400) begin
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = 8'((n < 9) ? vt[vi].a[n] : vt[vi].b[n-9]);
      end
      #1;
      if (in_valid && c_in_ready) n++;
      @(negedge clk);
    end
    chk("load_count", n, 18);
    in_valid = 1'b1;
    in_data = 8'hAA;
    if (!dsel) start3 = 1'b1;
    #1;
    chk("in_ready_compute", {31'd0, c_in_ready}, 0);
    chk("busy_compute", {31'd0, c_busy}, 1);
    if (rst_mid) begin
      start3 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {31'd0, c_busy}, 0);
      chk("rst_out_valid", {31'd0, c_out_valid}, 0);
      chk("rst_out_data", 32'(c_out_data), 0);
      chk("rst_in_ready", {31'd0, c_in_ready}, 0);
      chk("rst_done", {31'd0, c_done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      return;
    end
    lat = 0;
    while (!c_out_valid && lat < 200) begin
      @(negedge clk);
      start3 = 1'b0;
      #1;
      lat++;
    end
    start3 = 1'b0;
    chk("compute_latency", lat, dsel ? 36 : 12);
    in_valid = 1'b0;
    stalled = 1'b0;
    hold = '0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      guard++;
      out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) chk("stall_hold", 32'(c_out_data), 32'(hold));
      if (!c_out_valid) begin
        chk("out_valid_drain", 0, 1);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        lst = last_q.pop_front();
        chk("out_data", 32'(c_out_data), 32'(e));
        chk("out_last", {31'd0, c_out_last}, {31'd0, lst});
        stalled = 1'b0;
      end else begin
        hold = c_out_data;
        stalled = 1'b1;
      end
      @(negedge clk);
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    last_q.delete();
    out_ready = 1'b0;
    #1;
    chk("done_pulse", {31'd0, c_done}, 1);
    chk("out_valid_after", {31'd0, c_out_valid}, 0);
    @(negedge clk);
    #1;
    chk("done_low", {31'd0, c_done}, 0);
    chk("idle_busy", {31'd0, c_busy}, 0);
  endtask

  initial begin
    vt[0] = '{sm: 1'b0,
              a: '{1, 0, 0, 0, 1, 0, 0, 0, 1},
              b: '{1, 2, 3, 4, 5, 6, 7, 8, 9},
              e: '{1, 2, 3, 4, 5, 6, 7, 8, 9}};
    vt[1] = '{sm: 1'b0,
              a: '{default: 255},
              b: '{default: 255},
              e: '{default: 195075}};
    vt[2] = '{sm: 1'b1,
              a: '{default: -128},
              b: '{default: -128},
              e: '{default: 49152}};
    vt[3] = '{sm: 1'b1,
              a: '{default: -1},
              b: '{default: 2},
              e: '{default: -6}};
    vt[4] = '{sm: 1'b1,
              a: '{1, -1, 2, 0, 3, -2, -4, 1, 0},
              b: '{2, 0, -1, 1, 5, 3, -3, 2, 4},
              e: '{-5, -1, 4, 9, 11, 1, -7, 5, 7}};

    #2;
    chk("reset_busy", {31'd0, busy3}, 0);
    chk("reset_in_ready", {31'd0, i3.in_ready}, 0);
    chk("reset_out_valid", {31'd0, i3.out_valid}, 0);
    chk("reset_out_last", {31'd0, i3.out_last}, 0);
    chk("reset_out_data", 32'(i3.out_data), 0);
    chk("reset_done", {31'd0, done3}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) do_job(v, 1'b0, 1'b0, 1'b0);
    do_job(0, 1'b0, 1'b1, 1'b0);
    do_job(0, 1'b0, 1'b0, 1'b1);
    do_job(0, 1'b0, 1'b0, 1'b0);
    do_job(0, 1'b1, 1'b0, 1'b0);
    do_job(4, 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
